// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two requesters (ALU, load) share one write port.
// Round-robin on contention, one-cycle registered output stage, x0 writes dropped.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] WriteData,
  output logic [15:0]       wr_count,
  output logic [15:0]       drop_count,
  output logic              prio_state
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  prio_e             prio_q, prio_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [15:0]       drop_count_q, drop_count_d;

  logic              grant_a, grant_b, accept, commit, drop;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  // Handshake: a transfer on X happens at a rising edge where X_valid and
  // X_ready are both 1; an ungranted requester keeps valid/rd/data stable.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    if (rst_n && !hold) begin
      grant_a = a_valid && (!b_valid || prio_q == PRIO_A);
      grant_b = b_valid && (!a_valid || prio_q == PRIO_B);
    end
    accept   = grant_a || grant_b;
    sel_rd   = grant_b ? b_rd : a_rd;
    sel_data = grant_b ? b_data : a_data;
    commit   = accept && (sel_rd != '0);
    drop     = accept && (sel_rd == '0);
  end

  always_comb begin
    prio_d       = prio_q;
    regwrite_d   = commit;
    rd_d         = rd_q;
    wdata_d      = wdata_q;
    wr_count_d   = wr_count_q;
    drop_count_d = drop_count_q;
    if (grant_a) prio_d = PRIO_B;
    else if (grant_b) prio_d = PRIO_A;
    if (commit) begin
      rd_d    = sel_rd;
      wdata_d = sel_data;
      if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
    end
    if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= PRIO_A;
      regwrite_q   <= 1'b0;
      rd_q         <= '0;
      wdata_q      <= '0;
      wr_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      prio_q       <= prio_d;
      regwrite_q   <= regwrite_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
      wr_count_q   <= wr_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign RegWrite   = regwrite_q;
  assign rd         = rd_q;
  assign WriteData  = wdata_q;
  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;
  assign prio_state = prio_q;

endmodule
